// File: rtl/csel_pkg.sv
// Shared definitions for the carry-select sequencer: FSM state type,
// default geometry and a configuration legality check.
package csel_pkg;

  localparam int unsigned CSEL_WIDTH = 16;
  localparam int unsigned CSEL_SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } csel_state_e;

  // WIDTH must be a non-zero whole multiple of SLICE.
  function automatic bit csel_cfg_ok(input int unsigned width, input int unsigned slice);
    return (slice != 0) && (width >= slice) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/csel_slice.sv
// Combinational SLICE-bit carry-select stage: two candidate sums
// (carry-in 0 and 1) followed by a 1-bit select on the running carry.
module csel_slice #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             sel_cin,
  output logic [SLICE-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [SLICE:0] sum0;
  logic [SLICE:0] sum1;
  logic           msb_in0;
  logic           msb_in1;

  assign sum0 = {1'b0, a_s} + {1'b0, b_s};
  assign sum1 = {1'b0, a_s} + {1'b0, b_s} + (SLICE+1)'(1);

  // Carry into the MSB bit recovered from the MSB sum bit and its operands.
  assign msb_in0 = a_s[SLICE-1] ^ b_s[SLICE-1] ^ sum0[SLICE-1];
  assign msb_in1 = a_s[SLICE-1] ^ b_s[SLICE-1] ^ sum1[SLICE-1];

  assign s        = sel_cin ? sum1[SLICE-1:0] : sum0[SLICE-1:0];
  assign c_out    = sel_cin ? sum1[SLICE]     : sum0[SLICE];
  assign c_msb_in = sel_cin ? msb_in1         : msb_in0;

endmodule

// File: rtl/carry_select_sequencer.sv
// Multi-cycle WIDTH-bit adder stepping one shared carry-select slice
// across the operands, LSB slice first, with valid/ready on both sides.
module carry_select_sequencer
  import csel_pkg::*;
#(
  parameter int unsigned WIDTH = CSEL_WIDTH,
  parameter int unsigned SLICE = CSEL_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  if (!csel_cfg_ok(WIDTH, SLICE)) begin : g_bad_cfg
    $error("carry_select_sequencer: WIDTH must be a non-zero multiple of SLICE");
  end

  csel_state_e      state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] sl_s;
  logic             sl_c;
  logic             sl_cm;

  csel_slice #(.SLICE(SLICE)) u_slice (
    .a_s      (a_q[idx_q*SLICE +: SLICE]),
    .b_s      (b_q[idx_q*SLICE +: SLICE]),
    .sel_cin  (carry_q),
    .s        (sl_s),
    .c_out    (sl_c),
    .c_msb_in (sl_cm)
  );

  // Slices assemble in acc_q; the visible result only updates on the last
  // slice so sum/cout/ovf stay stable outside RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[idx_q*SLICE +: SLICE] = sl_s;
        carry_d = sl_c;
        if (idx_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = sl_c;
          ovf_d   = sl_cm ^ sl_c;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_carry_select_sequencer.sv
// Directed, table-driven bench for carry_select_sequencer (WIDTH=16, SLICE=4)
// plus hand-written backpressure, mid-operation reset and back-to-back sequences.
module tb_carry_select_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  carry_select_sequencer #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[9];
  vec_t bb[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      n_bad++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and wait (bounded) for out_valid.
  task automatic start_op(input vec_t v, output int lat, output int busy_cnt);
    a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = ~v.a; b = ~v.b; cin = ~v.cin;
    lat = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_xfer", out_valid, 0);
    check("in_ready_after_xfer", in_ready, 1);
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, "_sum"}, sum, v.s);
    check({tag, "_cout"}, cout, v.co);
    check({tag, "_ovf"}, ovf, v.ov);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt;
    int nacc, nres, cyc;
    int acc_cyc[3];
    logic prev_busy;

    vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
    vecs[8] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven operations
    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i], lat, bcnt);
      check_result($sformatf("vec%0d", i), vecs[i]);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, 4);
      finish_op();
    end

    // Backpressure: result held, new operands ignored
    start_op(vecs[0], lat, bcnt);
    for (int k = 0; k < 3; k++) begin
      in_valid = (k % 2 == 0);
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      tick();
      check_result($sformatf("bp%0d", k), vecs[0]);
      check($sformatf("bp%0d_in_ready", k), in_ready, 0);
      check($sformatf("bp%0d_out_valid", k), out_valid, 1);
      check($sformatf("bp%0d_busy", k), busy, 0);
    end
    in_valid = 1'b0;
    finish_op();
    check("bp_no_accept", busy, 0);
    check("bp_sum_after", sum, 16'h2345);

    // Reset during slice-2 cycle
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sum", sum, 16'h0000);
    check("midrst_cout", cout, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_op(vecs[4], lat, bcnt);
    check_result("postrst", vecs[4]);
    check("postrst_latency", lat, 4);
    finish_op();

    // Back-to-back with in_valid and out_ready held high
    bb[0] = vecs[0];
    bb[1] = vecs[2];
    bb[2] = vecs[3];
    acc_cyc = '{0, 0, 0};
    nacc = 0;
    nres = 0;
    prev_busy = 1'b0;
    out_ready = 1'b1;
    a = bb[0].a; b = bb[0].b; cin = bb[0].cin; in_valid = 1'b1;
    for (cyc = 0; cyc < 60 && nres < 3; cyc++) begin
      tick();
      if (busy && !prev_busy && nacc < 3) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc < 3) begin
          a = bb[nacc].a; b = bb[nacc].b; cin = bb[nacc].cin;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid && nres < 3) begin
        check_result($sformatf("b2b%0d", nres), bb[nres]);
        nres++;
      end
      prev_busy = busy;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("b2b_results", nres, 3);
    check("b2b_accepts", nacc, 3);
    check("b2b_spacing01", acc_cyc[1] - acc_cyc[0], 6);
    check("b2b_spacing12", acc_cyc[2] - acc_cyc[1], 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
